// File: rtl/accelerator_pkg.sv
// Shared types and constants for the accelerator control sequencer.
// The state code is one-hot with S_IDLE as the all-zero code, so state_o reads 0 out of reset.
package accelerator_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 20;
  localparam int MODE_WIDTH = 4;

  localparam logic [MODE_WIDTH-1:0] MODE_STREAM  = 4'd1;
  localparam logic [MODE_WIDTH-1:0] MODE_IMG2COL = 4'd2;

  localparam int NUM_PARAM   = 3;
  localparam int PARAM_W_IDX = 0;
  localparam int PARAM_H_IDX = 1;
  localparam int PARAM_K_IDX = 2;

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00000,
    S_PARAM   = 5'b00010,
    S_STREAM  = 5'b00100,
    S_IMG2COL = 5'b01000,
    S_FIN     = 5'b10000
  } accelerator_state_t;

  function automatic logic is_valid_mode(input logic [MODE_WIDTH-1:0] m);
    return (m == MODE_STREAM) || (m == MODE_IMG2COL);
  endfunction

endpackage

// File: rtl/accel_img2col_agu.sv
// im2col address generator: nested oy/ox/ky/kx counters with running row offsets.
// A linear stream is the degenerate case H=K=1, W=N.
module accel_img2col_agu
  import accelerator_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [DATA_WIDTH-1:0] w,
  input  logic [DATA_WIDTH-1:0] h,
  input  logic [DATA_WIDTH-1:0] k,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  localparam logic [DATA_WIDTH-1:0] ONE_D = DATA_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] w_q;
  logic [ADDR_WIDTH-1:0] oy_row;
  logic [ADDR_WIDTH-1:0] row;
  logic [DATA_WIDTH-1:0] lim_oy, lim_ox, lim_k;
  logic [DATA_WIDTH-1:0] oy, ox, ky, kx;

  // oy_row = oy*W and row = (oy+ky)*W, both advanced by +W instead of multiplying.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      w_q    <= '0;
      oy_row <= '0;
      row    <= '0;
      lim_oy <= '0;
      lim_ox <= '0;
      lim_k  <= '0;
      oy     <= '0;
      ox     <= '0;
      ky     <= '0;
      kx     <= '0;
    end else if (load) begin
      base_q <= base;
      w_q    <= ADDR_WIDTH'(w);
      lim_oy <= h - k;
      lim_ox <= w - k;
      lim_k  <= k - ONE_D;
      oy_row <= '0;
      row    <= '0;
      oy     <= '0;
      ox     <= '0;
      ky     <= '0;
      kx     <= '0;
    end else if (step) begin
      if (kx != lim_k) begin
        kx <= kx + ONE_D;
      end else begin
        kx <= '0;
        if (ky != lim_k) begin
          ky  <= ky + ONE_D;
          row <= row + w_q;
        end else begin
          ky <= '0;
          if (ox != lim_ox) begin
            ox  <= ox + ONE_D;
            row <= oy_row;
          end else begin
            ox     <= '0;
            oy     <= oy + ONE_D;
            oy_row <= oy_row + w_q;
            row    <= oy_row + w_q;
          end
        end
      end
    end
  end

  assign addr = base_q + row + ADDR_WIDTH'(ox) + ADDR_WIDTH'(kx);
  assign last = (oy == lim_oy) && (ox == lim_ox) && (ky == lim_k) && (kx == lim_k);

endmodule

// File: rtl/accel_ctrl_seq.sv
// Job sequencer: fetches W/H/K, validates them, streams source addresses to the datapath and
// reports completion once the datapath drains.
module accel_ctrl_seq
  import accelerator_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [MODE_WIDTH-1:0] mode_i,
  input  logic [ADDR_WIDTH-1:0] param_base_i,
  input  logic [ADDR_WIDTH-1:0] src_base_i,
  output logic                  param_rd_en_o,
  output logic [ADDR_WIDTH-1:0] param_addr_o,
  input  logic [DATA_WIDTH-1:0] param_rdata_i,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [ADDR_WIDTH-1:0] req_addr_o,
  output logic                  req_last_o,
  input  logic                  dp_idle_i,
  output logic [4:0]            state_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam logic [1:0] CAP_W     = 2'(PARAM_W_IDX + 1);
  localparam logic [1:0] CAP_H     = 2'(PARAM_H_IDX + 1);
  localparam logic [1:0] CAP_K     = 2'(PARAM_K_IDX + 1);
  localparam logic [1:0] LAST_READ = 2'(NUM_PARAM - 1);
  localparam logic [DATA_WIDTH-1:0] ONE_D = DATA_WIDTH'(1);

  accelerator_state_t    state;
  logic [MODE_WIDTH-1:0] mode_q;
  logic [ADDR_WIDTH-1:0] src_base_q;
  logic [1:0]            pcnt;
  logic [DATA_WIDTH-1:0] p_w, p_h;
  logic                  is_stream;
  logic                  k_bad;
  logic                  agu_load, agu_step, agu_last;
  logic [DATA_WIDTH-1:0] agu_h, agu_k;

  // Word K is still on the read bus during the last PARAM cycle, so it is used directly.
  assign is_stream = (mode_q == MODE_STREAM);
  assign k_bad     = (param_rdata_i == '0) || (param_rdata_i > p_w) || (param_rdata_i > p_h);
  assign agu_load  = (state == S_PARAM) && (pcnt == CAP_K);
  assign agu_step  = req_valid_o && req_ready_i;
  assign agu_h     = is_stream ? ONE_D : p_h;
  assign agu_k     = is_stream ? ONE_D : param_rdata_i;

  accel_img2col_agu u_agu (
    .clk  (clk),
    .rst  (rst),
    .load (agu_load),
    .step (agu_step),
    .base (src_base_q),
    .w    (p_w),
    .h    (agu_h),
    .k    (agu_k),
    .addr (req_addr_o),
    .last (agu_last)
  );

  // Handshake: an address transfers on any cycle with req_valid_o && req_ready_i; while valid is
  // high and ready is low the address and last flag are held, and valid never drops until a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      mode_q        <= '0;
      src_base_q    <= '0;
      pcnt          <= '0;
      p_w           <= '0;
      p_h           <= '0;
      param_rd_en_o <= 1'b0;
      param_addr_o  <= '0;
      req_valid_o   <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            mode_q     <= mode_i;
            src_base_q <= src_base_i;
            busy_o     <= 1'b1;
            if (is_valid_mode(mode_i)) begin
              state         <= S_PARAM;
              err_o         <= 1'b0;
              pcnt          <= '0;
              param_rd_en_o <= 1'b1;
              param_addr_o  <= param_base_i;
            end else begin
              state <= S_FIN;
              err_o <= 1'b1;
            end
          end
        end
        S_PARAM: begin
          pcnt <= pcnt + 2'd1;
          if (pcnt < LAST_READ) begin
            param_rd_en_o <= 1'b1;
            param_addr_o  <= param_addr_o + ADDR_WIDTH'(1);
          end else begin
            param_rd_en_o <= 1'b0;
          end
          if (pcnt == CAP_W) p_w <= param_rdata_i;
          if (pcnt == CAP_H) p_h <= param_rdata_i;
          if (pcnt == CAP_K) begin
            if (is_stream) begin
              state <= (p_w == '0) ? S_FIN : S_STREAM;
            end else if (k_bad) begin
              state <= S_FIN;
              err_o <= 1'b1;
            end else begin
              state <= S_IMG2COL;
            end
          end
        end
        S_STREAM, S_IMG2COL: begin
          if (!req_valid_o) begin
            req_valid_o <= 1'b1;
          end else if (req_ready_i && agu_last) begin
            req_valid_o <= 1'b0;
            state       <= S_FIN;
          end
        end
        S_FIN: begin
          if (dp_idle_i) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: begin
          state       <= S_IDLE;
          busy_o      <= 1'b0;
          req_valid_o <= 1'b0;
        end
      endcase
    end
  end

  assign state_o    = state;
  assign req_last_o = req_valid_o && agu_last;

endmodule
